// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timekeeping core: 1 ms tick detection, run/pause/lap FSM,
// BCD time count mm:ss.mmm with lap snapshot, lap counter and sticky minute-wrap flag.
module stopwatch_ctrl #(
   parameter int MIN_LIMIT = 60
) (
   input  logic        clk_100mhz,
   input  logic        rst_n,
   input  logic        clk_1ms,
   input  logic        btn_start_stop,
   input  logic        btn_lap_clear,
   output logic [27:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic [3:0]  lap_cnt,
   output logic        overflow
);

   typedef struct packed {
      logic [3:0] min_t;
      logic [3:0] min_o;
      logic [3:0] sec_t;
      logic [3:0] sec_o;
      logic [3:0] ms_h;
      logic [3:0] ms_t;
      logic [3:0] ms_o;
   } bcd_time_t;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

   localparam logic [3:0] MIN_MAX_T = 4'((MIN_LIMIT - 1) / 10);
   localparam logic [3:0] MIN_MAX_O = 4'((MIN_LIMIT - 1) % 10);

   state_t     state, state_nx;
   bcd_time_t  cnt, cnt_inc, cnt_nx;
   bcd_time_t  snap, snap_nx;
   logic [3:0] lap_nx;
   logic       ovf_nx;
   logic       clk_1ms_d;
   logic       tick, counting;
   logic       c_ms_t, c_ms_h, c_sec_o, c_sec_t, c_min, wrap;

   function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] max);
      return (d == max) ? 4'd0 : d + 4'd1;
   endfunction

   assign tick     = clk_1ms & ~clk_1ms_d;
   assign counting = tick & ((state == RUN) || (state == LAP));

   // Ripple carries: each digit advances only when every lower digit is at its maximum.
   assign c_ms_t  = (cnt.ms_o == 4'd9);
   assign c_ms_h  = c_ms_t  & (cnt.ms_t  == 4'd9);
   assign c_sec_o = c_ms_h  & (cnt.ms_h  == 4'd9);
   assign c_sec_t = c_sec_o & (cnt.sec_o == 4'd9);
   assign c_min   = c_sec_t & (cnt.sec_t == 4'd5);
   assign wrap    = c_min & (cnt.min_t == MIN_MAX_T) & (cnt.min_o == MIN_MAX_O);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      cnt_inc       = cnt;
      cnt_inc.ms_o  = bump(cnt.ms_o, 4'd9);
      if (c_ms_t)  cnt_inc.ms_t  = bump(cnt.ms_t, 4'd9);
      if (c_ms_h)  cnt_inc.ms_h  = bump(cnt.ms_h, 4'd9);
      if (c_sec_o) cnt_inc.sec_o = bump(cnt.sec_o, 4'd9);
      if (c_sec_t) cnt_inc.sec_t = bump(cnt.sec_t, 4'd5);
      if (wrap) begin
         cnt_inc.min_t = 4'd0;
         cnt_inc.min_o = 4'd0;
      end else if (c_min) begin
         cnt_inc.min_o = bump(cnt.min_o, 4'd9);
         if (cnt.min_o == 4'd9) cnt_inc.min_t = cnt.min_t + 4'd1;
      end
   end

   // Increment is decided by the pre-transition state; buttons then act on the result.
   always_comb begin
      state_nx = state;
      cnt_nx   = counting ? cnt_inc : cnt;
      snap_nx  = snap;
      lap_nx   = lap_cnt;
      ovf_nx   = overflow | (counting & wrap);
      case (state)
         IDLE: begin
            if (btn_start_stop) begin
               state_nx = RUN;
            end else if (btn_lap_clear) begin
               lap_nx = 4'd0;
               ovf_nx = 1'b0;
            end
         end
         RUN: begin
            if (btn_start_stop) begin
               state_nx = PAUSE;
            end else if (btn_lap_clear) begin
               state_nx = LAP;
               snap_nx  = cnt_nx;
               lap_nx   = (lap_cnt == 4'd15) ? lap_cnt : lap_cnt + 4'd1;
            end
         end
         LAP: begin
            if (btn_start_stop)     state_nx = PAUSE;
            else if (btn_lap_clear) state_nx = RUN;
         end
         PAUSE: begin
            if (btn_start_stop) begin
               state_nx = RUN;
            end else if (btn_lap_clear) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               snap_nx  = '0;
               lap_nx   = 4'd0;
               ovf_nx   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         snap       <= '0;
         clk_1ms_d  <= 1'b0;
         disp_bcd   <= '0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         lap_cnt    <= 4'd0;
         overflow   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state      <= state_nx;
         cnt        <= cnt_nx;
         snap       <= snap_nx;
         clk_1ms_d  <= clk_1ms;
         disp_bcd   <= (state_nx == LAP) ? snap_nx : cnt_nx;
         running    <= (state_nx == RUN) || (state_nx == LAP);
         lap_active <= (state_nx == LAP);
         lap_cnt    <= lap_nx;
         overflow   <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner sequences and
// randomized stimulus against a millisecond-integer reference model.
module tb_stopwatch_ctrl;

   localparam int MIN_LIMIT = 60;
   localparam int TOTAL_MS  = MIN_LIMIT * 60000;
   localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_LAP = 3;

   logic        clk_100mhz = 1'b0;
   logic        rst_n;
   logic        clk_1ms;
   logic        btn_start_stop;
   logic        btn_lap_clear;
   logic [27:0] disp_bcd;
   logic        running;
   logic        lap_active;
   logic [3:0]  lap_cnt;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   // Reference model: time held as a plain millisecond count.
   int   m_st, m_ms, m_snap, m_lap;
   logic m_ovf, m_prev;

   typedef struct {
      logic        ss, lc, lvl;
      logic [27:0] disp;
      logic        run, lap;
      logic [3:0]  lcnt;
      logic        ovf;
   } vec_t;
   vec_t vecs[16];

   stopwatch_ctrl #(.MIN_LIMIT(MIN_LIMIT)) dut (
      .clk_100mhz    (clk_100mhz),
      .rst_n         (rst_n),
      .clk_1ms       (clk_1ms),
      .btn_start_stop(btn_start_stop),
      .btn_lap_clear (btn_lap_clear),
      .disp_bcd      (disp_bcd),
      .running       (running),
      .lap_active    (lap_active),
      .lap_cnt       (lap_cnt),
      .overflow      (overflow)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   function automatic logic [27:0] to_bcd(input int t);
      int mn, sc, ms;
      mn = t / 60000;
      sc = (t / 1000) % 60;
      ms = t % 1000;
      return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10),
              4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = ST_IDLE; m_ms = 0; m_snap = 0; m_lap = 0; m_ovf = 1'b0; m_prev = 1'b0;
   endtask

   task automatic model_step(input logic ss, input logic lc, input logic lvl);
      logic tk;
      tk = lvl & ~m_prev;
      m_prev = lvl;
      if (tk && (m_st == ST_RUN || m_st == ST_LAP)) begin
         m_ms = (m_ms + 1) % TOTAL_MS;
         if (m_ms == 0) m_ovf = 1'b1;
      end
      if (ss) begin
         m_st = (m_st == ST_IDLE || m_st == ST_PAUSE) ? ST_RUN : ST_PAUSE;
      end else if (lc) begin
         case (m_st)
            ST_IDLE: begin m_lap = 0; m_ovf = 1'b0; end
            ST_RUN: begin
               m_st = ST_LAP; m_snap = m_ms;
               if (m_lap < 15) m_lap++;
            end
            ST_LAP: m_st = ST_RUN;
            default: begin
               m_st = ST_IDLE; m_ms = 0; m_snap = 0; m_lap = 0; m_ovf = 1'b0;
            end
         endcase
      end
   endtask

   task automatic check_model(input string tag);
      int shown;
      shown = (m_st == ST_LAP) ? m_snap : m_ms;
      check({tag, " disp"},    32'(disp_bcd),   32'(to_bcd(shown)));
      check({tag, " running"}, 32'(running),    32'(m_st == ST_RUN || m_st == ST_LAP));
      check({tag, " lap_act"}, 32'(lap_active), 32'(m_st == ST_LAP));
      check({tag, " lap_cnt"}, 32'(lap_cnt),    32'(m_lap));
      check({tag, " ovf"},     32'(overflow),   32'(m_ovf));
   endtask

   // Apply inputs at a falling edge, let one rising edge act, return at the next falling edge.
   task automatic drive(input logic ss, input logic lc, input logic lvl);
      btn_start_stop = ss;
      btn_lap_clear  = lc;
      clk_1ms        = lvl;
      model_step(ss, lc, lvl);
      @(negedge clk_100mhz);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b1);
         drive(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic force_count(input logic [27:0] v, input int ms);
      force dut.cnt = v;
      m_ms = ms;
      drive(1'b0, 1'b0, 1'b0);
      release dut.cnt;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " disp"},    32'(disp_bcd),   32'h0);
      check({tag, " running"}, 32'(running),    32'h0);
      check({tag, " lap_act"}, 32'(lap_active), 32'h0);
      check({tag, " lap_cnt"}, 32'(lap_cnt),    32'h0);
      check({tag, " ovf"},     32'(overflow),   32'h0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 28'h0000000, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 28'h0000001, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 28'h0000001, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 28'h0000002, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 28'h0000002, 1'b1, 1'b1, 4'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 28'h0000002, 1'b1, 1'b1, 4'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 28'h0000002, 1'b1, 1'b1, 4'd1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 28'h0000004, 1'b1, 1'b0, 4'd1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 28'h0000004, 1'b0, 1'b0, 4'd1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 28'h0000004, 1'b1, 1'b0, 4'd1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 28'h0000004, 1'b1, 1'b0, 4'd1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 28'h0000005, 1'b1, 1'b0, 4'd1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 28'h0000005, 1'b0, 1'b0, 4'd1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 28'h0000000, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 28'h0000000, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 28'h0000000, 1'b0, 1'b0, 4'd0, 1'b0};

      rst_n = 1'b0; clk_1ms = 1'b0; btn_start_stop = 1'b0; btn_lap_clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_100mhz);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk_100mhz);

      // Vector table from IDLE
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].ss, vecs[i].lc, vecs[i].lvl);
         check($sformatf("vec%0d disp", i),    32'(disp_bcd),   32'(vecs[i].disp));
         check($sformatf("vec%0d running", i), 32'(running),    32'(vecs[i].run));
         check($sformatf("vec%0d lap_act", i), 32'(lap_active), 32'(vecs[i].lap));
         check($sformatf("vec%0d lap_cnt", i), 32'(lap_cnt),    32'(vecs[i].lcnt));
         check($sformatf("vec%0d ovf", i),     32'(overflow),   32'(vecs[i].ovf));
      end

      // Basic count and pause freeze
      drive(1'b1, 1'b0, 1'b0);
      ticks(1234);
      check("count1234 disp", 32'(disp_bcd), 32'h0001234);
      check("count1234 running", 32'(running), 32'h1);
      drive(1'b1, 1'b0, 1'b0);
      ticks(100);
      check("pause disp", 32'(disp_bcd), 32'h0001234);
      check("pause running", 32'(running), 32'h0);
      check_model("pause");

      // Carry into minutes and wrap at MIN_LIMIT
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      force_count(28'h0059999, 59999);
      check("preload 59.999", 32'(disp_bcd), 32'h0059999);
      ticks(1);
      check("minute carry", 32'(disp_bcd), 32'h0100000);
      force_count(28'h5959999, (MIN_LIMIT - 1) * 60000 + 59999);
      ticks(1);
      check("wrap disp", 32'(disp_bcd), 32'h0000000);
      check("wrap ovf", 32'(overflow), 32'h1);
      check("wrap running", 32'(running), 32'h1);
      check_model("wrap");

      // Lap freeze and release
      ticks(2500);
      drive(1'b0, 1'b1, 1'b0);
      check("lap disp", 32'(disp_bcd), 32'h0002500);
      check("lap active", 32'(lap_active), 32'h1);
      check("lap cnt1", 32'(lap_cnt), 32'h1);
      ticks(500);
      check("lap frozen", 32'(disp_bcd), 32'h0002500);
      drive(1'b0, 1'b1, 1'b0);
      check("lap release disp", 32'(disp_bcd), 32'h0003000);
      check("lap release act", 32'(lap_active), 32'h0);

      // Lap counter saturation, then full clear
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         drive(1'b0, 1'b1, 1'b0);
      end
      check("lap saturate", 32'(lap_cnt), 32'd15);
      check("ovf sticky", 32'(overflow), 32'h1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      check_zero("clear");
      check_model("clear");

      // Buttons coincident with tick
      drive(1'b1, 1'b0, 1'b0);
      ticks(9);
      check("pre coinc", 32'(disp_bcd), 32'h0000009);
      drive(1'b1, 1'b0, 1'b1);
      check("run+ss+tick disp", 32'(disp_bcd), 32'h0000010);
      check("run+ss+tick running", 32'(running), 32'h0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      check("pause+ss+tick disp", 32'(disp_bcd), 32'h0000010);
      check("pause+ss+tick running", 32'(running), 32'h1);
      drive(1'b0, 1'b0, 1'b0);
      ticks(1);
      check("first tick after resume", 32'(disp_bcd), 32'h0000011);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      check("both btn running", 32'(running), 32'h0);
      check("both btn lap_act", 32'(lap_active), 32'h0);
      check("both btn lap_cnt", 32'(lap_cnt), 32'h1);
      check_model("both btn");

      // Asynchronous reset mid-run
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      ticks(5555);
      check("pre reset", 32'(disp_bcd), 32'h0005555);
      #2 rst_n = 1'b0;
      #1 check_zero("async reset");
      model_reset();
      @(negedge clk_100mhz);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0);
      ticks(1);
      check("post reset disp", 32'(disp_bcd), 32'h0000001);
      check_model("post reset");

      // Randomized stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 1)));
         check_model($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
